// File: rtl/parking_lot_controller.sv
// Parking lot occupancy counter with an entry-gate FSM.
// Counting follows the car-detection pulses and is independent of the gate.
// The gate opens for an arriving car while space remains, closes on entry or
// after a hold timeout, and signals a single refusal per arrival when full.
module parking_lot_controller #(
  parameter int CAPACITY  = 25,
  parameter int WIDTH     = 5,
  parameter int GATE_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enter,
  input  logic             exit,
  input  logic             arrive,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             gate_open,
  output logic             deny,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam logic [WIDTH-1:0] CAP_W  = WIDTH'(CAPACITY);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
  localparam logic [7:0]       HOLD_L = 8'(GATE_HOLD - 1);

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPEN    = 2'd1,
    CLOSING = 2'd2
  } gate_state_t;

  gate_state_t state, state_nxt;
  logic [7:0]  hold_cnt, hold_nxt;
  logic        deny_lock, lock_nxt;
  logic        deny_nxt;

  // Saturating occupancy update: simultaneous enter/exit cancel out, and the
  // count never moves past either end of its range.
  function automatic logic [WIDTH-1:0] next_count(
    input logic [WIDTH-1:0] cur,
    input logic             inc,
    input logic             dec,
    input logic             at_full,
    input logic             at_empty
  );
    logic [WIDTH-1:0] res;
    res = cur;
    if (inc && !dec && !at_full)
      res = cur + ONE_W;
    else if (dec && !inc && !at_empty)
      res = cur - ONE_W;
    return res;
  endfunction

  assign full  = (count == CAP_W);
  assign empty = (count == '0);

  // Occupancy count and sticky error flags; clear overrides the pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (clear) begin
      count         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      count <= next_count(count, enter, exit, full, empty);
      if (enter && !exit && full)
        overflow_err <= 1'b1;
      if (exit && !enter && empty)
        underflow_err <= 1'b1;
    end
  end

  // Gate FSM state, hold timer, refusal lockout and registered gate outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= CLOSED;
      hold_cnt  <= 8'd0;
      deny_lock <= 1'b0;
      deny      <= 1'b0;
      gate_open <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      deny_lock <= lock_nxt;
      deny      <= deny_nxt;
      gate_open <= (state_nxt == OPEN);
    end
  end

  // Next-state logic; the lockout keeps deny to one pulse per arrival and
  // re-arms only once arrive has dropped.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    deny_nxt  = 1'b0;
    lock_nxt  = arrive ? deny_lock : 1'b0;
    case (state)
      CLOSED: begin
        if (arrive && !full) begin
          state_nxt = OPEN;
          hold_nxt  = HOLD_L;
        end else if (arrive && full && !deny_lock) begin
          deny_nxt = 1'b1;
          lock_nxt = 1'b1;
        end
      end
      OPEN: begin
        if (enter || (hold_cnt == 8'd0))
          state_nxt = CLOSING;
        else
          hold_nxt = hold_cnt - 8'd1;
      end
      CLOSING: begin
        state_nxt = CLOSED;
      end
      default: begin
        state_nxt = CLOSED;
      end
    endcase
  end

endmodule
